cc_bus_arbiter: RTL and testbench
=================================

Name: cc_bus_arbiter

Overview:
- Arbitrates the shared 4-bit datapath bus between two requesters: the control unit (6-bit control selection code) and the register-file port (5-bit register selection code).
- Drives the bus mux's selector and both selection-code inputs from registered outputs.
- Uses round-robin priority with a bounded hold time and a one-cycle turnaround between owners.
- Sits directly in front of the bus mux in the datapath.

Parameters:
DATAWIDTH_MUX_SELECTION_REG, 5, width of register selection code
DATAWIDTH_MUX_SELECTION_CONTROL, 6, width of control selection code
MAX_HOLD, 4, maximum consecutive owned cycles while the other side is requesting
HOLD_CNT_WIDTH, 3, hold counter width; must satisfy 2^HOLD_CNT_WIDTH > MAX_HOLD
MAX_CODE, 11, highest selection code the mux decodes to a non-default channel

Ports:
CC_BUSARB_CLOCK_50  in  1  system clock, rising edge
CC_BUSARB_RESET_InLow  in  1  asynchronous active-low reset
CC_BUSARB_ctrlReq_In  in  1  control unit requests bus
CC_BUSARB_ctrlCode_InBUS  in  DATAWIDTH_MUX_SELECTION_CONTROL  control selection code
CC_BUSARB_regReq_In  in  1  register port requests bus
CC_BUSARB_regCode_InBUS  in  DATAWIDTH_MUX_SELECTION_REG  register selection code
CC_BUSARB_ctrlGrant_Out  out  1  control unit owns bus this cycle
CC_BUSARB_regGrant_Out  out  1  register port owns bus this cycle
CC_BUSARB_selector_OutBUS  out  1  mux selector; 0 = control path, 1 = register path
CC_BUSARB_control_OutBUS  out  DATAWIDTH_MUX_SELECTION_CONTROL  to mux control input
CC_BUSARB_registro_OutBUS  out  DATAWIDTH_MUX_SELECTION_REG  to mux register input
CC_BUSARB_busValid_Out  out  1  bus carries a granted transfer this cycle
CC_BUSARB_codeError_Out  out  1  granted code exceeds MAX_CODE

Behaviour:
- Clock and reset: one clock, CC_BUSARB_CLOCK_50. Reset CC_BUSARB_RESET_InLow is asynchronous, active-low.
- Reset values:
  - State IDLE.
  - All grants, busValid and codeError = 0.
  - Both code outputs = 0. Selector = 0.
  - holdCnt = 0. lastOwner = REG, so CTRL wins the first tie.
- All outputs are registered. Grant latency is 1 cycle: a request sampled at edge N yields grant in the cycle after edge N.
- States: IDLE, OWN_CTRL, OWN_REG, TURN.
- IDLE or TURN, at each edge:
  - Both requests high: go to OWN_x for the requester that is not lastOwner.
  - One request high: go to that requester's OWN state.
  - No request: go to IDLE.
  - Entering OWN_x sets lastOwner = x and holdCnt = 1.
- OWN_x, at each edge:
  - req_x low: go to TURN if the other requester is requesting, else IDLE.
  - req_x high, other requesting, holdCnt == MAX_HOLD: preempt, go to TURN.
  - Otherwise stay in OWN_x. holdCnt increments and saturates at MAX_HOLD.
  - With no contention the owner keeps the bus indefinitely.
- Output loading:
  - On every edge whose next state is OWN_x: grant_x = 1, busValid = 1.
  - selector = 0 for CTRL, 1 for REG.
  - The owner's code input sampled at that edge is loaded into its code output; the non-owner code output is forced to 0.
- TURN and IDLE cycles:
  - Grants and busValid = 0. Both code outputs = 0, so the mux output is 0.
  - Selector holds its last value.
  - TURN always lasts exactly 1 cycle.
- codeError:
  - Registered alongside the code; 1 when busValid and the loaded code > MAX_CODE, else 0. It is not sticky.
  - The offending code is still forwarded.
- Simultaneous events:
  - Requests rising in the same cycle are resolved by round-robin.
  - An owner dropping its request on the same edge that preemption would fire gives the same result (TURN).
- A requester may change its code every owned cycle; each valid cycle carries exactly one sampled code.
- Reset asserted mid-ownership: outputs clear immediately (asynchronously). The first grant after release follows the reset tie rule.

Decomposition:
- Package cc_bus_arbiter_pkg holds:
  - state encoding localparams (IDLE=2'b00, OWN_CTRL=2'b01, OWN_REG=2'b10, TURN=2'b11);
  - owner encoding (CTRL=0, REG=1, matching selector polarity);
  - default MAX_CODE.
- One natural sub-module: cc_bus_hold_counter, a saturating counter with load-1 and increment enables.
- The FSM and output registers stay in the top module.

Test Plan:
- Reset pulse mid-run → all outputs 0, selector 0, asynchronously, before the next clock edge.
- ctrlReq=1 with ctrlCode=6'd5 for 3 cycles, regReq=0 →
  - ctrlGrant=1, selector=0, control_OutBUS=5, busValid=1 from cycle +1 for 3 cycles;
  - then IDLE with outputs 0.
- Both requests high from reset, continuously, ctrlCode=6'd3, regCode=5'd9 →
  - 4 cycles CTRL (control_OutBUS=3);
  - 1 TURN cycle (busValid=0);
  - 4 cycles REG (selector=1, registro_OutBUS=9);
  - TURN, then CTRL again.
- REG owning, regReq drops after 2 owned cycles while ctrlReq=1 → TURN for 1 cycle, then ctrlGrant=1.
- ctrlReq=1 with ctrlCode=6'd12 → busValid=1, control_OutBUS=12, codeError=1. Next code 6'd11 → codeError=0.
- regReq alone held for 10 cycles → regGrant stays 1 for 10 consecutive cycles with no preemption; holdCnt saturates at 4.

Source files
------------

// File: rtl/cc_bus_arbiter_pkg.sv
// cc_bus_arbiter_pkg: shared state/owner encodings and defaults for the bus arbiter.
package cc_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        OWN_CTRL = 2'b01,
        OWN_REG  = 2'b10,
        TURN     = 2'b11
    } state_t;
    // Owner encoding doubles as the mux selector value.
    localparam logic CTRL = 1'b0;
    localparam logic REG  = 1'b1;
    localparam int DEFAULT_MAX_CODE = 11;
endpackage

// File: rtl/cc_bus_hold_counter.sv
// cc_bus_hold_counter: saturating hold counter with load-to-1 and increment enables.
module cc_bus_hold_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= WIDTH'(1);
        else if (inc && cnt != WIDTH'(MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cc_bus_arbiter.sv
// cc_bus_arbiter: round-robin owner of the shared mux bus with bounded hold and one-cycle turnaround.
module cc_bus_arbiter
    import cc_bus_arbiter_pkg::*;
#(
    parameter int DATAWIDTH_MUX_SELECTION_REG     = 5,
    parameter int DATAWIDTH_MUX_SELECTION_CONTROL = 6,
    parameter int MAX_HOLD                        = 4,
    parameter int HOLD_CNT_WIDTH                  = 3,
    parameter int MAX_CODE                        = DEFAULT_MAX_CODE
) (
    input  logic                                       CC_BUSARB_CLOCK_50,
    input  logic                                       CC_BUSARB_RESET_InLow,
    input  logic                                       CC_BUSARB_ctrlReq_In,
    input  logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_BUSARB_ctrlCode_InBUS,
    input  logic                                       CC_BUSARB_regReq_In,
    input  logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_BUSARB_regCode_InBUS,
    output logic                                       CC_BUSARB_ctrlGrant_Out,
    output logic                                       CC_BUSARB_regGrant_Out,
    output logic                                       CC_BUSARB_selector_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_BUSARB_control_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_BUSARB_registro_OutBUS,
    output logic                                       CC_BUSARB_busValid_Out,
    output logic                                       CC_BUSARB_codeError_Out
);
    state_t state, nxt;
    logic last_owner, nxt_last;
    logic [HOLD_CNT_WIDTH-1:0] hold_cnt;
    logic hold_full, enter, stay;
    logic n_cg, n_rg, n_sel, n_err;
    logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] n_ctrl;
    logic [DATAWIDTH_MUX_SELECTION_REG-1:0] n_reg;

    assign hold_full = hold_cnt == HOLD_CNT_WIDTH'(MAX_HOLD);

    always_comb begin
        nxt = state;
        case (state)
            OWN_CTRL: nxt = !CC_BUSARB_ctrlReq_In ? (CC_BUSARB_regReq_In ? TURN : IDLE)
                          : (CC_BUSARB_regReq_In && hold_full) ? TURN : OWN_CTRL;
            OWN_REG:  nxt = !CC_BUSARB_regReq_In ? (CC_BUSARB_ctrlReq_In ? TURN : IDLE)
                          : (CC_BUSARB_ctrlReq_In && hold_full) ? TURN : OWN_REG;
            // Ties go to whoever did not own the bus last.
            default:  nxt = (CC_BUSARB_ctrlReq_In && CC_BUSARB_regReq_In) ? (last_owner == REG ? OWN_CTRL : OWN_REG)
                          : CC_BUSARB_ctrlReq_In ? OWN_CTRL
                          : CC_BUSARB_regReq_In ? OWN_REG : IDLE;
        endcase
        n_cg     = nxt == OWN_CTRL;
        n_rg     = nxt == OWN_REG;
        enter    = (n_cg || n_rg) && nxt != state;
        stay     = (n_cg || n_rg) && nxt == state;
        n_sel    = n_cg ? CTRL : n_rg ? REG : CC_BUSARB_selector_OutBUS;
        nxt_last = n_cg ? CTRL : n_rg ? REG : last_owner;
        n_ctrl   = n_cg ? CC_BUSARB_ctrlCode_InBUS : '0;
        n_reg    = n_rg ? CC_BUSARB_regCode_InBUS : '0;
        n_err    = n_cg ? int'(CC_BUSARB_ctrlCode_InBUS) > MAX_CODE
                 : n_rg ? int'(CC_BUSARB_regCode_InBUS) > MAX_CODE : 1'b0;
    end

    always_ff @(posedge CC_BUSARB_CLOCK_50 or negedge CC_BUSARB_RESET_InLow)
        if (!CC_BUSARB_RESET_InLow) begin
            state                     <= IDLE;
            last_owner                <= REG;
            CC_BUSARB_ctrlGrant_Out   <= 1'b0;
            CC_BUSARB_regGrant_Out    <= 1'b0;
            CC_BUSARB_selector_OutBUS <= CTRL;
            CC_BUSARB_control_OutBUS  <= '0;
            CC_BUSARB_registro_OutBUS <= '0;
            CC_BUSARB_busValid_Out    <= 1'b0;
            CC_BUSARB_codeError_Out   <= 1'b0;
        end else begin
            state                     <= nxt;
            last_owner                <= nxt_last;
            CC_BUSARB_ctrlGrant_Out   <= n_cg;
            CC_BUSARB_regGrant_Out    <= n_rg;
            CC_BUSARB_selector_OutBUS <= n_sel;
            CC_BUSARB_control_OutBUS  <= n_ctrl;
            CC_BUSARB_registro_OutBUS <= n_reg;
            CC_BUSARB_busValid_Out    <= n_cg || n_rg;
            CC_BUSARB_codeError_Out   <= n_err;
        end

    cc_bus_hold_counter #(
        .WIDTH(HOLD_CNT_WIDTH),
        .MAX  (MAX_HOLD)
    ) u_hold (
        .clk  (CC_BUSARB_CLOCK_50),
        .rst_n(CC_BUSARB_RESET_InLow),
        .load (enter),
        .inc  (stay),
        .cnt  (hold_cnt)
    );
endmodule

// File: tb/tb_cc_bus_arbiter.sv
// tb_cc_bus_arbiter: directed self-checking bench for cc_bus_arbiter.
module tb_cc_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ctrl_req = 1'b0, reg_req = 1'b0;
    logic [5:0] ctrl_code = '0;
    logic [4:0] reg_code = '0;
    logic cg, rg, sel, valid, err;
    logic [5:0] c_out;
    logic [4:0] r_out;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_bus_arbiter dut (
        .CC_BUSARB_CLOCK_50       (clk),
        .CC_BUSARB_RESET_InLow    (rst_n),
        .CC_BUSARB_ctrlReq_In     (ctrl_req),
        .CC_BUSARB_ctrlCode_InBUS (ctrl_code),
        .CC_BUSARB_regReq_In      (reg_req),
        .CC_BUSARB_regCode_InBUS  (reg_code),
        .CC_BUSARB_ctrlGrant_Out  (cg),
        .CC_BUSARB_regGrant_Out   (rg),
        .CC_BUSARB_selector_OutBUS(sel),
        .CC_BUSARB_control_OutBUS (c_out),
        .CC_BUSARB_registro_OutBUS(r_out),
        .CC_BUSARB_busValid_Out   (valid),
        .CC_BUSARB_codeError_Out  (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fields packed as {ctrlGrant, regGrant, selector, control, registro, busValid, codeError}.
    task automatic expect_bus(input string tag, input logic e_cg, input logic e_rg, input logic e_sel,
                              input logic [5:0] e_c, input logic [4:0] e_r, input logic e_v, input logic e_e);
        logic [15:0] obs, exp;
        obs = {cg, rg, sel, c_out, r_out, valid, err};
        exp = {e_cg, e_rg, e_sel, e_c, e_r, e_v, e_e};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #2 expect_bus("reset", 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0);
        #10 rst_n = 1'b1;
        // Control alone, code 5, sampled on three edges.
        ctrl_req = 1'b1; ctrl_code = 6'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_bus("ctrl_alone", 1'b1, 1'b0, 1'b0, 6'd5, 5'd0, 1'b1, 1'b0);
        end
        ctrl_req = 1'b0;
        tick();
        expect_bus("ctrl_idle", 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0);
        // Out-of-range code is forwarded and flagged; error clears with a legal code.
        ctrl_req = 1'b1; ctrl_code = 6'd12;
        tick();
        expect_bus("code12_err", 1'b1, 1'b0, 1'b0, 6'd12, 5'd0, 1'b1, 1'b1);
        ctrl_code = 6'd11;
        tick();
        expect_bus("code11_ok", 1'b1, 1'b0, 1'b0, 6'd11, 5'd0, 1'b1, 1'b0);
        // Asynchronous reset mid-ownership, observed before the next edge.
        #2 rst_n = 1'b0;
        #1 expect_bus("async_rst", 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0);
        ctrl_req = 1'b0;
        #3 rst_n = 1'b1;
        // Contention from reset: CTRL wins first, 4 cycles each with TURN between.
        ctrl_req = 1'b1; ctrl_code = 6'd3; reg_req = 1'b1; reg_code = 5'd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_bus("rr_ctrl", 1'b1, 1'b0, 1'b0, 6'd3, 5'd0, 1'b1, 1'b0);
        end
        tick();
        expect_bus("rr_turn1", 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_bus("rr_reg", 1'b0, 1'b1, 1'b1, 6'd0, 5'd9, 1'b1, 1'b0);
        end
        tick();
        expect_bus("rr_turn2_sel_hold", 1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_bus("rr_ctrl2", 1'b1, 1'b0, 1'b0, 6'd3, 5'd0, 1'b1, 1'b0);
        end
        tick();
        expect_bus("rr_turn3", 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0);
        // REG owns two cycles then drops while CTRL still waits.
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_bus("reg_two", 1'b0, 1'b1, 1'b1, 6'd0, 5'd9, 1'b1, 1'b0);
        end
        reg_req = 1'b0;
        tick();
        expect_bus("drop_turn", 1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0, 1'b0);
        tick();
        expect_bus("drop_ctrl", 1'b1, 1'b0, 1'b0, 6'd3, 5'd0, 1'b1, 1'b0);
        ctrl_req = 1'b0;
        tick();
        expect_bus("drop_idle", 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b0);
        // REG alone for 10 cycles, new code every cycle, never preempted.
        reg_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            reg_code = 5'(i * 3);
            tick();
            expect_bus("reg_alone", 1'b0, 1'b1, 1'b1, 6'd0, 5'(i * 3), 1'b1, (i * 3) > 11);
        end
        reg_req = 1'b0;
        tick();
        expect_bus("reg_idle_sel_hold", 1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0, 1'b0);
        // Simultaneous rise after REG owned last: CTRL wins.
        ctrl_req = 1'b1; ctrl_code = 6'd7; reg_req = 1'b1; reg_code = 5'd2;
        tick();
        expect_bus("tie_ctrl", 1'b1, 1'b0, 1'b0, 6'd7, 5'd0, 1'b1, 1'b0);
        ctrl_req = 1'b0; reg_req = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
